// File: rtl/req_ack_word_splitter_pkg.sv
// Shared definitions for the word splitter and its companion word packer:
// FSM state encoding and slice-count / index-width derivations.
package req_ack_word_splitter_pkg;

  typedef enum logic {
    SPLIT_IDLE = 1'b0,
    SPLIT_EMIT = 1'b1
  } split_state_e;

  function automatic int split_slice_count(input int data_w, input int slice_w);
    return data_w / slice_w;
  endfunction

  // Index must be at least one bit wide even for a single-slice word.
  function automatic int split_index_width(input int slice_count);
    return (slice_count > 1) ? $clog2(slice_count) : 1;
  endfunction

endpackage

// File: rtl/req_ack_word_splitter.sv
// Splits one wide REQ/ACK word into LSB-first narrow slices on a second
// REQ/ACK interface; a per-word last index allows short words.
module req_ack_word_splitter
  import req_ack_word_splitter_pkg::*;
#(
  parameter  int DATABITWIDTH  = 16,
  parameter  int SLICEBITWIDTH = 4,
  localparam int SLICECOUNT    = split_slice_count(DATABITWIDTH, SLICEBITWIDTH),
  localparam int INDEXBITWIDTH = split_index_width(SLICECOUNT)
) (
  input  logic                     clk,
  input  logic                     async_rst,
  input  logic                     clk_en,
  input  logic                     InputREQ,
  output logic                     InputACK,
  input  logic [DATABITWIDTH-1:0]  InputData,
  input  logic [INDEXBITWIDTH-1:0] InputLastIndex,
  output logic                     OutputREQ,
  input  logic                     OutputACK,
  output logic [SLICEBITWIDTH-1:0] OutputData,
  output logic                     OutputLast
);

  localparam logic [INDEXBITWIDTH-1:0] IDX_MAX = INDEXBITWIDTH'(SLICECOUNT - 1);

  split_state_e              state_q;
  logic [DATABITWIDTH-1:0]   holding_q;
  logic [INDEXBITWIDTH-1:0]  beat_q;
  logic [INDEXBITWIDTH-1:0]  last_q;
  logic [INDEXBITWIDTH-1:0]  last_d;

  logic busy;
  logic in_xfer;
  logic out_xfer;

  assign busy       = (state_q == SPLIT_EMIT);
  assign OutputREQ  = busy && clk_en;
  assign OutputData = holding_q[SLICEBITWIDTH-1:0];
  assign OutputLast = busy && (beat_q == last_q);
  // Combinational path from OutputACK lets the next word load on the final slice.
  assign InputACK   = clk_en && (!busy || (OutputLast && OutputACK));

  assign in_xfer  = InputREQ && InputACK;
  assign out_xfer = OutputREQ && OutputACK;
  assign last_d   = (InputLastIndex > IDX_MAX) ? IDX_MAX : InputLastIndex;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q   <= SPLIT_IDLE;
      holding_q <= '0;
      beat_q    <= '0;
      last_q    <= '0;
    end else if (clk_en) begin
      if (in_xfer) begin
        state_q   <= SPLIT_EMIT;
        holding_q <= InputData;
        beat_q    <= '0;
        last_q    <= last_d;
      end else if (out_xfer) begin
        if (OutputLast) begin
          state_q   <= SPLIT_IDLE;
          holding_q <= '0;
        end else begin
          holding_q <= holding_q >> SLICEBITWIDTH;
          beat_q    <= beat_q + 1'b1;
        end
      end
    end
  end

endmodule
